// File: rtl/seg_pkg.sv
// Shared constants for the seven-segment scan controller: digit count,
// blank/off patterns and the active-low hex-to-segment table.
package seg_pkg;

   localparam int          NUM_DIGITS = 4;
   localparam logic [6:0]  SEG_BLANK  = 7'h7F;
   localparam logic [3:0]  AN_OFF     = 4'hF;

   // Active-low {g,f,e,d,c,b,a} patterns for nibbles 0..F
   localparam logic [6:0] HEX_SEG [16] = '{
      7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
      7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
      7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
      7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
   };

endpackage

// File: rtl/seg_scan_ctrl_if.sv
// Load/ack handshake between the result producer and the scan controller.
interface seg_scan_ctrl_if;
   import seg_pkg::*;

   logic [4*NUM_DIGITS-1:0] value_in;
   logic [NUM_DIGITS-1:0]   blank_in;
   logic                    load;
   logic                    load_ack;

   modport master (output value_in, output blank_in, output load, input load_ack);
   modport slave  (input value_in, input blank_in, input load, output load_ack);

endinterface

// File: rtl/hex_to_seg7.sv
// Combinational nibble to active-low seven-segment decoder.
module hex_to_seg7
   import seg_pkg::*;
(
   input  logic [3:0] nibble,
   output logic [6:0] seg
);

   assign seg = HEX_SEG[nibble];

endmodule

// File: rtl/seg_scan_ctrl.sv
// Four-digit multiplexed display scanner; staged data commits to the
// shadow registers only at frame boundaries so a frame never tears.
module seg_scan_ctrl
   import seg_pkg::*;
#(
   parameter int REFRESH_DIV = 100000
)
(
   input  logic            clk,
   input  logic            rst,
   seg_scan_ctrl_if.slave  bus,
   output logic            frame_start,
   output logic [3:0]      an,
   output logic [6:0]      seg_out
);

   localparam int             PW   = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
   localparam logic [PW-1:0]  PMAX = PW'(REFRESH_DIV - 1);

   logic [PW-1:0] pcnt, pcnt_nxt;
   logic [1:0]    idx, idx_nxt;
   logic          tick, bnd;
   logic [15:0]   stg_val, stg_val_nxt, cur_val, cur_val_nxt;
   logic [3:0]    stg_blk, stg_blk_nxt, cur_blk, cur_blk_nxt;
   logic          pend, pend_nxt, ack_nxt;
   logic [3:0]    nib, an_nxt;
   logic [6:0]    seg_dec, seg_nxt;

   // A load on the boundary cycle bypasses staging so it shows immediately
   always_comb begin
      tick        = (pcnt == PMAX);
      bnd         = tick && (idx == 2'd3);
      pcnt_nxt    = tick ? '0 : pcnt + PW'(1);
      idx_nxt     = tick ? idx + 2'd1 : idx;
      stg_val_nxt = stg_val;
      stg_blk_nxt = stg_blk;
      cur_val_nxt = cur_val;
      cur_blk_nxt = cur_blk;
      pend_nxt    = pend;
      ack_nxt     = 1'b0;
      if (bnd) begin
         pend_nxt = 1'b0;
         if (bus.load) begin
            cur_val_nxt = bus.value_in;
            cur_blk_nxt = bus.blank_in;
            ack_nxt     = 1'b1;
         end else if (pend) begin
            cur_val_nxt = stg_val;
            cur_blk_nxt = stg_blk;
            ack_nxt     = 1'b1;
         end
      end else if (bus.load) begin
         stg_val_nxt = bus.value_in;
         stg_blk_nxt = bus.blank_in;
         pend_nxt    = 1'b1;
      end
   end

   always_comb begin
      nib = cur_val_nxt[{idx_nxt, 2'b00} +: 4];
   end

   hex_to_seg7 u_dec (
      .nibble (nib),
      .seg    (seg_dec)
   );

   // Outputs look ahead to the next digit so they switch on the same edge as idx
   always_comb begin
      an_nxt  = cur_blk_nxt[idx_nxt] ? AN_OFF : ~(4'b0001 << idx_nxt);
      seg_nxt = cur_blk_nxt[idx_nxt] ? SEG_BLANK : seg_dec;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         pcnt         <= '0;
         idx          <= 2'd0;
         pend         <= 1'b0;
         stg_val      <= '0;
         stg_blk      <= '0;
         cur_val      <= '0;
         cur_blk      <= '0;
         an           <= 4'b1110;
         seg_out      <= HEX_SEG[0];
         bus.load_ack <= 1'b0;
         frame_start  <= 1'b0;
      end else begin
         pcnt         <= pcnt_nxt;
         idx          <= idx_nxt;
         pend         <= pend_nxt;
         stg_val      <= stg_val_nxt;
         stg_blk      <= stg_blk_nxt;
         cur_val      <= cur_val_nxt;
         cur_blk      <= cur_blk_nxt;
         an           <= an_nxt;
         seg_out      <= seg_nxt;
         bus.load_ack <= ack_nxt;
         frame_start  <= bnd;
      end
   end

endmodule
